msg_event_queue: RTL and testbench
==================================

# msg_event_queue

Downstream consumer of the environment-variable stage's message outputs (MSG_Sign, MSG_OUT, PID_out). The block captures each emitted message together with the PID active at emission and buffers it in a small FIFO. It then presents messages one at a time to the board display logic, holding each for a programmable number of cycles. This way, back-to-back EMIT_MSG instructions are not lost when the display is slower than the instruction stream.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- HOLD_CYCLES, 50000000: display hold time per message, in clk cycles; at least 1.
- CNT_W, 26: hold-timer width; must hold HOLD_CYCLES-1.
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- MSG_Sign  in  1  message-emit flag from the environment stage; a level that may stay high for several cycles.
- MSG_OUT  in  5  message code, valid while MSG_Sign is high.
- PID_out  in  5  current PID, tagged onto each captured message.
- Ack  in  1  single-cycle pulse; releases the displayed message early.
- Clear  in  1  synchronous flush.
- Display_Msg  out  5  message code on display.
- Display_PID  out  5  PID tag of the displayed message.
- Display_Valid  out  1  high while a message is being shown.
- Count  out  clog2(DEPTH+1)  number of FIFO entries, not counting the displayed message.
- Overflow  out  1  sticky; set when a message is dropped.

## Operation
- Capture:
  - A 1-bit register prev_sign holds MSG_Sign from the previous cycle.
  - push = MSG_Sign & ~prev_sign, i.e. only a rising edge captures a message.
  - On push, the entry {PID_out, MSG_OUT} is written at the write pointer.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits; both wrap naturally.
  - Count is a separate register ranging 0..DEPTH.
  - Push while full with no same-cycle pop: the entry is dropped, Overflow is set, and pointers and Count are unchanged.
  - Push while full with a same-cycle pop: both are performed, Count stays DEPTH, Overflow is unchanged.
  - Push and pop while empty is impossible, because a pop requires Count > 0.
- Display FSM has two states, IDLE and SHOW.
  - IDLE: Display_Valid = 0. If Count > 0: pop the head into Display_Msg/Display_PID, load timer = HOLD_CYCLES-1, go to SHOW.
  - SHOW: Display_Valid = 1. Each cycle the timer decrements. A release occurs when timer == 0 or Ack = 1.
  - On release with Count > 0: pop the next entry, reload the timer, stay in SHOW (Display_Valid stays high, no gap).
  - On release with Count == 0: go to IDLE.
  - Ack in IDLE is ignored. Ack coinciding with timer == 0 causes exactly one release.
- Display_Msg and Display_PID keep their last values in IDLE; only Display_Valid qualifies them.
- Clear:
  - Priority over push, pop and the FSM.
  - Next state: pointers = 0, Count = 0, Overflow = 0, FSM = IDLE, Display_Valid = 0.
  - A push in the same cycle as Clear is discarded. prev_sign still updates.

## Timing
- Reset (asynchronous, active-low):
  - Outputs: Display_Msg = 0, Display_PID = 0, Display_Valid = 0, Count = 0, Overflow = 0.
  - Internal: FSM = IDLE, prev_sign = 0, timer = 0, pointers = 0.
  - Consequence of prev_sign = 0: if MSG_Sign is already high at reset release, that counts as one push on the first edge.
- Reset mid-SHOW immediately drops Display_Valid and discards all queued entries.
- Latency with an empty FIFO and IDLE state:
  - Edge E samples the rising MSG_Sign and writes the entry; Count = 1 after E.
  - Edge E+1 pops it; after E+1, Display_Valid = 1 and Count = 0.
- Hold: Display_Valid stays high for exactly HOLD_CYCLES cycles per message when there is no Ack.
- Ack sampled high in SHOW releases at that edge; the next message, or IDLE, is visible after that edge.
- Throughput: at most one push and one pop per cycle.

## Test plan
- Single message, HOLD_CYCLES=4: PID_out=3, pulse MSG_Sign with MSG_OUT=5'd9.
  - Display_Valid rises 2 edges after the pulse, with Display_Msg=9 and Display_PID=3.
  - Display_Valid stays high exactly 4 cycles, then returns to 0.
- Level hold: MSG_Sign held high 10 cycles with MSG_OUT=7 -> exactly one message is captured; Count never exceeds 1.
- Overflow, DEPTH=8, HOLD_CYCLES=100: send 10 separated pulses with codes 1..10.
  - Code 1 is displayed; codes 2..9 are queued (Count=8); code 10 is dropped and Overflow=1.
  - Drain order is 1..9.
- Ack: 3 messages queued, HOLD_CYCLES=100, pulse Ack each time a message has been shown 2 cycles.
  - Messages advance on each Ack with no Display_Valid gap.
  - After the third Ack, the FSM is IDLE and Display_Valid=0.
- Clear and push together: 4 entries queued, Clear asserted together with a new MSG_Sign edge.
  - Next cycle: Count=0, Display_Valid=0, Overflow=0.
  - No message appears afterwards.
- Async reset mid-SHOW: assert reset between edges -> Display_Valid drops immediately with no clock; after release, a fresh pulse is displayed normally.

Source files
------------

// File: rtl/msg_event_queue.sv
// Message capture FIFO feeding a hold-timed display stage.
// Rising edges of MSG_Sign enqueue {PID_out, MSG_OUT}; each entry is shown for HOLD_CYCLES or until Ack.
module msg_event_queue #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MSG_Sign,
  input  logic [4:0]                   MSG_OUT,
  input  logic [4:0]                   PID_out,
  input  logic                         Ack,
  input  logic                         Clear,
  output logic [4:0]                   Display_Msg,
  output logic [4:0]                   Display_PID,
  output logic                         Display_Valid,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SHOW = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

  logic             state_q, state_d;
  logic             prev_sign_q, prev_sign_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       msg_q, msg_d;
  logic [4:0]       pid_q, pid_d;

  logic [9:0]       mem_q [DEPTH];

  logic             push;
  logic             release_now;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [9:0]       head;

  always_comb begin
    push        = MSG_Sign & ~prev_sign_q;
    release_now = (state_q == ST_SHOW) & ((timer_q == '0) | Ack);
    pop         = (count_q != '0) & ((state_q == ST_IDLE) | release_now);
    full        = (count_q == FULL_CNT);
    // A full FIFO still accepts a push when the display pops in the same cycle.
    wr_en       = push & (~full | pop) & ~Clear;
    head        = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d     = state_q;
    prev_sign_d = MSG_Sign;
    timer_d     = timer_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    msg_d       = msg_q;
    pid_d       = pid_q;

    if (Clear) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push & full & ~pop) ovf_d = 1'b1;

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        msg_d    = head[4:0];
        pid_d    = head[9:5];
        timer_d  = HOLD_LOAD;
        state_d  = ST_SHOW;
      end else if (release_now) begin
        state_d  = ST_IDLE;
      end else if (state_q == ST_SHOW) begin
        timer_d  = timer_q - CNT_W'(1);
      end

      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prev_sign_q <= 1'b0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      msg_q       <= '0;
      pid_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_sign_q <= prev_sign_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      msg_q       <= msg_d;
      pid_q       <= pid_d;
    end
  end

  // Storage needs no reset: Count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {PID_out, MSG_OUT};
  end

  assign Display_Msg   = msg_q;
  assign Display_PID   = pid_q;
  assign Display_Valid = (state_q == ST_SHOW);
  assign Count         = count_q;
  assign Overflow      = ovf_q;

endmodule

// File: tb/tb_msg_event_queue.sv
// Bench: table vectors and a random run against a queue model (hold 4), plus directed
// overflow / ack / clear / async-reset sequences on a second instance (hold 100).
module tb_msg_event_queue;

  localparam int DEPTH = 8;
  localparam int HA    = 4;
  localparam int HB    = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sign, ack, clr;
  logic [4:0] msg, pid;

  logic [4:0] a_msg, a_pid, b_msg, b_pid;
  logic       a_valid, b_valid, a_ovf, b_ovf;
  logic [3:0] a_count, b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msg_event_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_n), .MSG_Sign(sign), .MSG_OUT(msg), .PID_out(pid),
    .Ack(ack), .Clear(clr), .Display_Msg(a_msg), .Display_PID(a_pid),
    .Display_Valid(a_valid), .Count(a_count), .Overflow(a_ovf));

  msg_event_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HB), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_n), .MSG_Sign(sign), .MSG_OUT(msg), .PID_out(pid),
    .Ack(ack), .Clear(clr), .Display_Msg(b_msg), .Display_PID(b_pid),
    .Display_Valid(b_valid), .Count(b_count), .Overflow(b_ovf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a message queue plus the entry on display and how long it has been shown.
  logic [9:0] m_q[$];
  logic       m_show, m_ovf, m_prev;
  logic [9:0] m_disp;
  int         m_age;

  task automatic mreset();
    m_q.delete();
    m_show = 0; m_ovf = 0; m_prev = 0; m_disp = '0; m_age = 0;
  endtask

  task automatic mstep();
    logic p, rel, pop;
    if (clr) begin
      m_q.delete();
      m_show = 0;
      m_ovf  = 0;
    end else begin
      p   = sign && !m_prev;
      rel = m_show && (ack || m_age == HA - 1);
      pop = (!m_show || rel) && (m_q.size() > 0);
      if (pop) begin
        m_disp = m_q.pop_front();
        m_show = 1;
        m_age  = 0;
      end else if (rel) m_show = 0;
      else if (m_show) m_age++;
      if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back({pid, msg});
        else m_ovf = 1;
      end
    end
    m_prev = sign;
  endtask

  typedef struct {
    logic s; logic [4:0] m; logic [4:0] p; logic a; logic c;
    logic v; int cnt; logic [4:0] em; logic [4:0] ep;
  } vec_t;
  vec_t tv[$];

  function automatic void addv(logic s, logic [4:0] m, p, logic a, c, v, int cnt, logic [4:0] em, ep);
    tv.push_back('{s, m, p, a, c, v, cnt, em, ep});
  endfunction

  task automatic do_reset(input logic s_in);
    rst_n = 0; sign = s_in; ack = 0; clr = 0; msg = 0; pid = 0;
    cyc();
    rst_n = 1;
  endtask

  task automatic pulse(input logic [4:0] m, input logic [4:0] p);
    sign = 1; msg = m; pid = p;
    cyc();
    sign = 0;
    cyc();
  endtask

  initial begin
    rst_n = 1; sign = 0; ack = 0; clr = 0; msg = 0; pid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst.a_valid", a_valid, 0); chk("rst.a_count", a_count, 0);
    chk("rst.a_ovf", a_ovf, 0);     chk("rst.a_msg", a_msg, 0);
    chk("rst.a_pid", a_pid, 0);     chk("rst.b_valid", b_valid, 0);
    do_reset(0);

    // Single message, level hold, ack release, ack in idle, ack at timer expiry, clear.
    addv(1, 9, 3, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) addv(0, 9, 3, 0, 0, 1, 0, 9, 3);
    addv(0, 9, 3, 0, 0, 0, 0, 0, 0);
    addv(1, 7, 3, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) addv(1, 7, 3, 0, 0, 1, 0, 7, 3);
    for (int k = 0; k < 5; k++) addv(1, 7, 3, 0, 0, 0, 0, 0, 0);
    addv(0, 7, 3, 0, 0, 0, 0, 0, 0);
    addv(1, 12, 4, 0, 0, 0, 1, 0, 0);
    addv(0, 12, 4, 0, 0, 1, 0, 12, 4);
    addv(0, 12, 4, 1, 0, 0, 0, 0, 0);
    addv(0, 12, 4, 1, 0, 0, 0, 0, 0);
    addv(1, 3, 1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) addv(0, 3, 1, 0, 0, 1, 0, 3, 1);
    addv(1, 20, 2, 1, 0, 0, 1, 0, 0);
    addv(0, 20, 2, 0, 0, 1, 0, 20, 2);
    addv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      sign = tv[i].s; msg = tv[i].m; pid = tv[i].p; ack = tv[i].a; clr = tv[i].c;
      cyc();
      chk($sformatf("vec%0d.valid", i), a_valid, tv[i].v);
      chk($sformatf("vec%0d.count", i), a_count, tv[i].cnt);
      chk($sformatf("vec%0d.ovf", i), a_ovf, 0);
      if (tv[i].v) begin
        chk($sformatf("vec%0d.msg", i), a_msg, tv[i].em);
        chk($sformatf("vec%0d.pid", i), a_pid, tv[i].ep);
      end
    end

    // Random run against the model; reset may release with MSG_Sign already high.
    for (int r = 0; r < 3; r++) begin
      do_reset(1'($urandom_range(0, 1)));
      mreset();
      m_prev = 0;
      for (int i = 0; i < 1500; i++) begin
        if (i == 0) sign = sign; else sign = 1'($urandom_range(0, 1));
        msg = 5'($urandom); pid = 5'($urandom);
        ack = ($urandom_range(0, 19) == 0);
        clr = ($urandom_range(0, 149) == 0);
        mstep();
        cyc();
        chk("rnd.valid", a_valid, m_show);
        chk("rnd.count", a_count, m_q.size());
        chk("rnd.ovf", a_ovf, m_ovf);
        chk("rnd.msg", a_msg, m_disp[4:0]);
        chk("rnd.pid", a_pid, m_disp[9:5]);
      end
    end

    // Ack advances queued messages with no valid gap.
    do_reset(0);
    pulse(21, 1); pulse(22, 1); pulse(23, 1);
    chk("ack.first", b_msg, 21);
    chk("ack.count", b_count, 2);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("ack.hold_valid", b_valid, 1);
      ack = 1;
      cyc();
      ack = 0;
      if (j < 2) begin
        chk("ack.adv_valid", b_valid, 1);
        chk("ack.adv_msg", b_msg, 22 + j);
      end else begin
        chk("ack.idle_valid", b_valid, 0);
      end
    end

    // Overflow: 1 shown, 2..9 queued, 10 dropped; then drain order.
    for (int k = 1; k <= 10; k++) pulse(5'(k), 5);
    chk("ovf.valid", b_valid, 1);
    chk("ovf.msg", b_msg, 1);
    chk("ovf.count", b_count, 8);
    chk("ovf.flag", b_ovf, 1);
    for (int k = 2; k <= 9; k++) begin
      ack = 1;
      cyc();
      ack = 0;
      chk("drain.msg", b_msg, k);
      chk("drain.valid", b_valid, 1);
      chk("drain.count", b_count, 9 - k);
    end
    ack = 1;
    cyc();
    ack = 0;
    chk("drain.idle", b_valid, 0);
    chk("drain.ovf_sticky", b_ovf, 1);

    // Clear coinciding with a push edge discards everything.
    for (int k = 1; k <= 5; k++) pulse(5'(k), 2);
    chk("clr.pre_count", b_count, 4);
    sign = 1; msg = 30; clr = 1;
    cyc();
    clr = 0;
    chk("clr.count", b_count, 0);
    chk("clr.valid", b_valid, 0);
    chk("clr.ovf", b_ovf, 0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("clr.after_valid", b_valid, 0);
      chk("clr.after_count", b_count, 0);
    end
    sign = 0;
    cyc();

    // Async reset between edges while showing.
    pulse(17, 6);
    chk("ars.showing", b_valid, 1);
    pulse(19, 6);
    #3 rst_n = 0;
    #1;
    chk("ars.b_valid", b_valid, 0);
    chk("ars.b_count", b_count, 0);
    cyc();
    rst_n = 1;
    sign = 1; msg = 18; pid = 7;
    cyc();
    sign = 0;
    chk("ars.push_count", b_count, 1);
    chk("ars.push_valid", b_valid, 0);
    cyc();
    chk("ars.show_valid", b_valid, 1);
    chk("ars.show_msg", b_msg, 18);
    chk("ars.show_pid", b_pid, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
